// File: rtl/coin_datapath_pkg.sv
// Shared defaults for the vending-machine coin datapath and the controller
// state encodings used by the top level and its bench.
package coin_datapath_pkg;

  localparam int W_DEF     = 8;
  localparam int PRICE_DEF = 100;
  // Saturating sums are formed this many bits wider than W before clamping.
  localparam int SUM_EXT   = 1;

  typedef enum logic [1:0] {
    ST_INITIAL = 2'b00,
    ST_COUNT   = 2'b01,
    ST_DONE    = 2'b10,
    ST_CHANGE  = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/coin_datapath_if.sv
// Controller, coin-acceptor and change-dispenser signals of the coin datapath.
// The master side is the controller/environment, the slave side the datapath.
interface coin_datapath_if
  import coin_datapath_pkg::*;
#(
  parameter int W = W_DEF
);
  logic         rst;
  logic         done;
  logic         chout;
  logic         coin_valid;
  logic [W-1:0] coin_value;
  logic         coin_ready;
  logic         coin_reject;
  logic         End;
  logic         ch;
  logic         chg_valid;
  logic         chg_ack;
  logic [W-1:0] chg_rem;
  logic [W-1:0] sale_count;

  modport master (
    output rst, done, chout, coin_valid, coin_value, chg_ack,
    input  coin_ready, coin_reject, End, ch, chg_valid, chg_rem, sale_count
  );

  modport slave (
    input  rst, done, chout, coin_valid, coin_value, chg_ack,
    output coin_ready, coin_reject, End, ch, chg_valid, chg_rem, sale_count
  );
endinterface

// File: rtl/coin_datapath_change_dispenser.sv
// Holds the outstanding change balance: adds newly computed change and pays
// out one unit per valid/ack handshake, saturating at 2^W-1.
module change_dispenser
  import coin_datapath_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         ack,
  output logic [W-1:0] rem,
  output logic         valid
);

  logic         dec;
  logic [W-1:0] add;
  logic [W-1:0] rem_next;

  // dec is only ever set while r >= 1, so the subtraction cannot underflow.
  function automatic logic [W-1:0] sat_step(input logic [W-1:0] r,
                                            input logic         d,
                                            input logic [W-1:0] a);
    logic [W+SUM_EXT-1:0] s;
    s = {{SUM_EXT{1'b0}}, r} + {{SUM_EXT{1'b0}}, a} - {{(W+SUM_EXT-1){1'b0}}, d};
    return (|s[W+SUM_EXT-1:W]) ? {W{1'b1}} : s[W-1:0];
  endfunction

  assign valid    = (rem != '0);
  assign dec      = ack && valid;
  assign add      = load ? load_value : '0;
  assign rem_next = sat_step(rem, dec, add);

  always_ff @(posedge clk) begin
    if (reset) rem <= '0;
    else       rem <= rem_next;
  end

endmodule

// File: rtl/coin_datapath.sv
// Coin accumulator, price comparison, coin gating and sales counter for the
// vending-machine controller; change payout is delegated to change_dispenser.
module coin_datapath
  import coin_datapath_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int PRICE = PRICE_DEF
) (
  input logic           clk,
  input logic           reset,
  coin_datapath_if.slave bus
);

  localparam logic [W-1:0] PRICE_W = W'(PRICE);

  logic [W-1:0] total;
  logic [W-1:0] sale_count_r;
  logic         reject_p1;
  logic         accept;
  logic [W-1:0] change;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W+SUM_EXT-1:0] s;
    s = {{SUM_EXT{1'b0}}, a} + {{SUM_EXT{1'b0}}, b};
    return (|s[W+SUM_EXT-1:W]) ? {W{1'b1}} : s[W-1:0];
  endfunction

  // Status seen by the controller comes straight off the registered total.
  assign bus.End         = (total >= PRICE_W);
  assign bus.ch          = (total > PRICE_W);
  assign bus.coin_ready  = !bus.rst && !bus.End;
  assign bus.coin_reject = reject_p1;
  assign bus.sale_count  = sale_count_r;
  assign accept          = bus.coin_valid && bus.coin_ready;

  // A change request without overpayment is a controller error; it loads nothing.
  assign change = bus.ch ? (total - PRICE_W) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      total        <= '0;
      reject_p1    <= 1'b0;
      sale_count_r <= '0;
    end else begin
      reject_p1 <= bus.coin_valid && !bus.coin_ready;
      if (bus.rst)     total <= '0;
      else if (accept) total <= sat_add(total, bus.coin_value);
      if (bus.done)    sale_count_r <= sale_count_r + 1'b1;
    end
  end

  change_dispenser #(.W(W)) u_dispenser (
    .clk        (clk),
    .reset      (reset),
    .load       (bus.chout),
    .load_value (change),
    .ack        (bus.chg_ack),
    .rem        (bus.chg_rem),
    .valid      (bus.chg_valid)
  );

endmodule

// File: tb/tb_coin_datapath.sv
// Bench for coin_datapath: directed scenarios plus randomized traffic, all
// compared against an integer-level reference of the coin/change/sales rules.
module tb_coin_datapath;

  localparam int W        = 8;
  localparam int PRICE    = 100;
  localparam int PRICE_HI = 254;
  localparam int MAXV     = 255;

  logic clk;
  logic reset;

  coin_datapath_if #(.W(W)) bus ();
  coin_datapath_if #(.W(W)) bus_hi ();

  coin_datapath #(.W(W), .PRICE(PRICE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  coin_datapath #(.W(W), .PRICE(PRICE_HI)) dut_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run;
  int n_fail;

  // Reference state in plain integers.
  int m_total;
  int m_rem;
  int m_sales;
  int m_rej;

  task automatic tick();
    int rdy;
    int chg;
    int nr;
    @(posedge clk);
    if (reset) begin
      m_total = 0; m_rem = 0; m_sales = 0; m_rej = 0;
    end else begin
      rdy   = (!bus.rst && m_total < PRICE) ? 1 : 0;
      chg   = (bus.chout && m_total > PRICE) ? m_total - PRICE : 0;
      nr    = m_rem - ((bus.chg_ack && m_rem != 0) ? 1 : 0) + chg;
      m_rej = (bus.coin_valid && rdy == 0) ? 1 : 0;
      if (bus.rst) m_total = 0;
      else if (bus.coin_valid && rdy == 1) begin
        m_total = m_total + int'(bus.coin_value);
        if (m_total > MAXV) m_total = MAXV;
      end
      m_rem   = (nr > MAXV) ? MAXV : nr;
      m_sales = (m_sales + (bus.done ? 1 : 0)) % 256;
    end
    #1;
  endtask

  task automatic coin(input int v);
    bus.coin_valid = 1'b1;
    bus.coin_value = W'(v);
    tick();
    bus.coin_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.coin_valid = 1'b1;
    bus.coin_value = 8'd50;
    tick();
    tick();
    n_run++; if (bus.End !== 1'b0) begin n_fail++; $display("FAIL reset_end actual=%0b expected=0", bus.End); end
    n_run++; if (bus.ch !== 1'b0) begin n_fail++; $display("FAIL reset_ch actual=%0b expected=0", bus.ch); end
    n_run++; if (bus.chg_rem !== 8'd0) begin n_fail++; $display("FAIL reset_chg_rem actual=%0d expected=0", bus.chg_rem); end
    n_run++; if (bus.sale_count !== 8'd0) begin n_fail++; $display("FAIL reset_sales actual=%0d expected=0", bus.sale_count); end
    n_run++; if (bus.coin_reject !== 1'b0) begin n_fail++; $display("FAIL reset_reject actual=%0b expected=0", bus.coin_reject); end
    n_run++; if (bus.chg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_chg_valid actual=%0b expected=0", bus.chg_valid); end
    reset = 1'b0;
    bus.coin_valid = 1'b0;
    tick();
  endtask

  task automatic test_exact_price();
    bus.rst = 1'b1; tick(); bus.rst = 1'b0;
    coin(50);
    n_run++; if (bus.End !== 1'b0) begin n_fail++; $display("FAIL exact_half_end actual=%0b expected=0", bus.End); end
    coin(50);
    n_run++; if (bus.End !== 1'b1) begin n_fail++; $display("FAIL exact_end actual=%0b expected=1", bus.End); end
    n_run++; if (bus.ch !== 1'b0) begin n_fail++; $display("FAIL exact_ch actual=%0b expected=0", bus.ch); end
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    n_run++; if (bus.sale_count !== 8'd1) begin n_fail++; $display("FAIL exact_sales actual=%0d expected=1", bus.sale_count); end
    n_run++; if (bus.chg_rem !== 8'd0) begin n_fail++; $display("FAIL exact_chg_rem actual=%0d expected=0", bus.chg_rem); end
    bus.rst = 1'b1; tick(); bus.rst = 1'b0;
    n_run++; if (bus.End !== 1'b0) begin n_fail++; $display("FAIL exact_clear_end actual=%0b expected=0", bus.End); end
  endtask

  task automatic test_overpay();
    int cnt;
    coin(50); coin(25); coin(50);
    n_run++; if ({bus.End, bus.ch} !== 2'b11) begin n_fail++; $display("FAIL overpay_status actual=%b expected=11", {bus.End, bus.ch}); end
    bus.chout = 1'b1; bus.done = 1'b1; tick(); bus.chout = 1'b0; bus.done = 1'b0;
    n_run++; if (bus.chg_rem !== 8'd25) begin n_fail++; $display("FAIL overpay_load actual=%0d expected=25", bus.chg_rem); end
    cnt = 0;
    bus.rst = 1'b1; bus.chg_ack = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.chg_valid === 1'b1) cnt++;
      tick();
    end
    bus.rst = 1'b0; bus.chg_ack = 1'b0;
    n_run++; if (cnt != 25) begin n_fail++; $display("FAIL overpay_acks actual=%0d expected=25", cnt); end
    n_run++; if (bus.chg_rem !== 8'd0) begin n_fail++; $display("FAIL overpay_drained actual=%0d expected=0", bus.chg_rem); end
    n_run++; if (bus.chg_valid !== 1'b0) begin n_fail++; $display("FAIL overpay_valid actual=%0b expected=0", bus.chg_valid); end
  endtask

  task automatic test_gating();
    coin(100);
    n_run++; if (bus.coin_reject !== 1'b0) begin n_fail++; $display("FAIL gate_accept_reject actual=%0b expected=0", bus.coin_reject); end
    n_run++; if (bus.coin_ready !== 1'b0) begin n_fail++; $display("FAIL gate_ready actual=%0b expected=0", bus.coin_ready); end
    coin(10);
    n_run++; if (bus.coin_reject !== 1'b1) begin n_fail++; $display("FAIL gate_reject_pulse actual=%0b expected=1", bus.coin_reject); end
    tick();
    n_run++; if (bus.coin_reject !== 1'b0) begin n_fail++; $display("FAIL gate_reject_end actual=%0b expected=0", bus.coin_reject); end
    n_run++; if ({bus.End, bus.ch} !== 2'b10) begin n_fail++; $display("FAIL gate_total_held actual=%b expected=10", {bus.End, bus.ch}); end
    bus.chout = 1'b1; tick(); bus.chout = 1'b0;
    n_run++; if (bus.chg_rem !== 8'd0) begin n_fail++; $display("FAIL gate_no_change actual=%0d expected=0", bus.chg_rem); end
    bus.rst = 1'b1; tick(); bus.rst = 1'b0;
  endtask

  task automatic test_overlap();
    coin(105);
    bus.chout = 1'b1; tick(); bus.chout = 1'b0;
    n_run++; if (bus.chg_rem !== 8'd5) begin n_fail++; $display("FAIL overlap_setup actual=%0d expected=5", bus.chg_rem); end
    bus.rst = 1'b1; tick(); bus.rst = 1'b0;
    coin(110);
    bus.chout = 1'b1; bus.chg_ack = 1'b1; tick(); bus.chout = 1'b0; bus.chg_ack = 1'b0;
    n_run++; if (bus.chg_rem !== 8'd14) begin n_fail++; $display("FAIL overlap_ack_load actual=%0d expected=14", bus.chg_rem); end
    bus.rst = 1'b1; tick(); bus.rst = 1'b0;
    coin(255);
    bus.chout = 1'b1; tick(); bus.chout = 1'b0;
    n_run++; if (bus.chg_rem !== 8'd169) begin n_fail++; $display("FAIL overlap_accum actual=%0d expected=169", bus.chg_rem); end
    bus.rst = 1'b1; tick(); bus.rst = 1'b0;
    coin(255);
    bus.chout = 1'b1; tick(); bus.chout = 1'b0;
    n_run++; if (bus.chg_rem !== 8'd255) begin n_fail++; $display("FAIL overlap_chg_sat actual=%0d expected=255", bus.chg_rem); end
    bus.rst = 1'b1; tick(); bus.rst = 1'b0;
  endtask

  task automatic test_total_saturation();
    bus_hi.rst = 1'b1; tick(); bus_hi.rst = 1'b0;
    bus_hi.coin_valid = 1'b1; bus_hi.coin_value = 8'd250; tick();
    n_run++; if (bus_hi.End !== 1'b0) begin n_fail++; $display("FAIL sat_below_price actual=%0b expected=0", bus_hi.End); end
    bus_hi.coin_value = 8'd10; tick(); bus_hi.coin_valid = 1'b0;
    n_run++; if ({bus_hi.End, bus_hi.ch} !== 2'b11) begin n_fail++; $display("FAIL sat_status actual=%b expected=11", {bus_hi.End, bus_hi.ch}); end
    bus_hi.chout = 1'b1; tick(); bus_hi.chout = 1'b0;
    n_run++; if (bus_hi.chg_rem !== 8'd1) begin n_fail++; $display("FAIL sat_total_255 actual=%0d expected=1", bus_hi.chg_rem); end
  endtask

  task automatic test_random();
    logic [6:0] exp_v;
    logic [6:0] act_v;
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 49) == 0);
      bus.rst        = ($urandom_range(0, 7) == 0);
      bus.done       = ($urandom_range(0, 9) == 0);
      bus.chout      = ($urandom_range(0, 5) == 0);
      bus.chg_ack    = $urandom_range(0, 1) == 1;
      bus.coin_valid = $urandom_range(0, 1) == 1;
      bus.coin_value = ($urandom_range(0, 15) == 0) ? 8'd255 : W'($urandom_range(0, 120));
      tick();
      exp_v = {m_total >= PRICE, m_total > PRICE, !bus.rst && m_total < PRICE,
               m_rej != 0, m_rem != 0, 2'b00};
      act_v = {bus.End, bus.ch, bus.coin_ready, bus.coin_reject, bus.chg_valid, 2'b00};
      n_run++; if (act_v !== exp_v) begin n_fail++; $display("FAIL rand_flags cycle=%0d actual=%b expected=%b", i, act_v, exp_v); end
      n_run++; if (int'(bus.chg_rem) != m_rem || bus.chg_rem === 'x) begin n_fail++; $display("FAIL rand_chg_rem cycle=%0d actual=%0d expected=%0d", i, bus.chg_rem, m_rem); end
      n_run++; if (int'(bus.sale_count) != m_sales || bus.sale_count === 'x) begin n_fail++; $display("FAIL rand_sales cycle=%0d actual=%0d expected=%0d", i, bus.sale_count, m_sales); end
    end
    reset = 1'b0; bus.rst = 1'b0; bus.done = 1'b0; bus.chout = 1'b0;
    bus.chg_ack = 1'b0; bus.coin_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    reset = 1'b1; tick(); reset = 1'b0;
    coin(107);
    bus.chout = 1'b1; tick(); bus.chout = 1'b0;
    bus.rst = 1'b1; tick(); bus.rst = 1'b0;
    coin(60);
    n_run++; if (bus.chg_rem !== 8'd7) begin n_fail++; $display("FAIL midrst_setup actual=%0d expected=7", bus.chg_rem); end
    bus.chg_ack = 1'b1; reset = 1'b1; tick(); reset = 1'b0; bus.chg_ack = 1'b0;
    n_run++; if (bus.chg_rem !== 8'd0) begin n_fail++; $display("FAIL midrst_chg_rem actual=%0d expected=0", bus.chg_rem); end
    n_run++; if (bus.chg_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_chg_valid actual=%0b expected=0", bus.chg_valid); end
    coin(40);
    n_run++; if (bus.End !== 1'b0) begin n_fail++; $display("FAIL midrst_total_cleared actual=%0b expected=0", bus.End); end
    bus.done = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    n_run++; if (bus.sale_count !== 8'd255) begin n_fail++; $display("FAIL sales_max actual=%0d expected=255", bus.sale_count); end
    tick();
    bus.done = 1'b0;
    n_run++; if (bus.sale_count !== 8'd0) begin n_fail++; $display("FAIL sales_wrap actual=%0d expected=0", bus.sale_count); end
    n_run++; if (int'(bus.sale_count) != m_sales) begin n_fail++; $display("FAIL sales_model actual=%0d expected=%0d", bus.sale_count, m_sales); end
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    m_total = 0; m_rem = 0; m_sales = 0; m_rej = 0;
    reset = 1'b1;
    bus.rst = 1'b0; bus.done = 1'b0; bus.chout = 1'b0;
    bus.coin_valid = 1'b0; bus.coin_value = '0; bus.chg_ack = 1'b0;
    bus_hi.rst = 1'b0; bus_hi.done = 1'b0; bus_hi.chout = 1'b0;
    bus_hi.coin_valid = 1'b0; bus_hi.coin_value = '0; bus_hi.chg_ack = 1'b0;
    test_reset();
    test_exact_price();
    test_overpay();
    test_gating();
    test_overlap();
    test_total_saturation();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_datapath.md
Name: coin_datapath

Overview:
- Datapath partner of the vending-machine controller FSM (states Initial/Count/Done/Change).
- Consumes the controller's control outputs: rst, done, chout.
- Produces the status inputs the controller samples: End, ch.
- Accumulates inserted coin values against a fixed price, computes change, pays change out one unit per handshake, and keeps a sales counter.

Parameters:
- W, 8, width of coin value, accumulator, change and sales counter.
- PRICE, 100, item price in units; must satisfy 0 < PRICE < 2^W-1.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-high global reset.
- rst  input  1  controller clear: zero the accumulator (high in controller Initial state).
- done  input  1  controller sale-complete indication (Done or Change state).
- chout  input  1  controller change indication (Change state).
- coin_valid  input  1  coin presented this cycle.
- coin_value  input  W  value of presented coin, in units.
- coin_ready  output  1  coin accepted this cycle when coin_valid && coin_ready.
- coin_reject  output  1  registered one-cycle pulse: coin presented while coin_ready was low.
- End  output  1  total >= PRICE.
- ch  output  1  total > PRICE.
- chg_valid  output  1  change unit pending (chg_rem != 0).
- chg_ack  input  1  dispenser took one unit.
- chg_rem  output  W  remaining change units.
- sale_count  output  W  completed sales, wraps modulo 2^W.

Behaviour:
- Reset: on a clk edge with reset=1, total=0, chg_rem=0, sale_count=0, coin_reject=0. Reset has priority over every other event, mid-sale or mid-payout; a partial sale is lost.
- Derived combinationally from registered state:
  - End = (total >= PRICE); ch = (total > PRICE).
  - coin_ready = !rst && !End; chg_valid = (chg_rem != 0).
  - Zero-cycle path from total to End/ch, so the controller sees End one edge after the accepting coin edge.
- Accumulator priority per edge: reset > rst (total <= 0) > accepted coin (total <= sat(total + coin_value)) > hold.
- Saturation: the sum is computed in W+1 bits and clamped to 2^W-1. A coin of value 0 is accepted with no total change.
- Coin gating:
  - Coins offered while End=1 or rst=1 are not added; coin_reject pulses on the next cycle.
  - total therefore holds through controller Done/Change and is cleared only in Initial.
- Change load:
  - On an edge with chout=1, change = total - PRICE (W bits, total > PRICE guaranteed since ch=1) is added to chg_rem.
  - If chg_ack && chg_valid on the same edge: chg_rem <= sat(chg_rem - 1 + change).
  - Otherwise chg_rem <= sat(chg_rem + change).
  - chout with total <= PRICE (protocol violation) loads 0.
- Payout handshake:
  - chg_valid && chg_ack decrements chg_rem by 1 per edge.
  - chg_ack while chg_valid=0 is ignored; no underflow.
  - Payout runs independently of the next sale; new change accumulates onto the remainder.
- Sales counter: sale_count increments on each edge with done=1 (one cycle per sale from the controller), wrapping 2^W-1 -> 0.
- Latency: coin edge N -> End/ch valid after N. Controller Change state at edge N+1 -> chg_rem loaded at edge N+2 -> first chg_valid after N+2.

Decomposition:
- Shared include file: PRICE default, W default, and the saturating-add width rule (W+1 intermediate). Controller state encodings (Initial 00, Count 01, Done 10, Change 11) live there too, for the bench and top level.
- One sub-module, change_dispenser: owns chg_rem, load/decrement/saturation logic and chg_valid. coin_datapath keeps the accumulator, coin gating, End/ch and sale_count.

Test Plan:
- reset=1 for 2 cycles with coin_valid=1 value 50 -> total=0, End=0, chg_rem=0, sale_count=0, coin_reject=0.
- Exact price: with the controller looping, coins 50,50 -> End=1, ch=0; Done state -> sale_count=1; chg_rem stays 0; Initial clears total.
- Overpay: coins 50,25,50 (total 125) -> End=1, ch=1; Change state -> chg_rem=25 next edge. chg_ack held high -> chg_valid for exactly 25 acks, chg_rem reaches 0 and stays there.
- Gating: coin 100, then coin 10 offered while End=1 -> coin_reject pulses once, total stays 100, no change loaded.
- Overlap: chg_rem=5, chout with total 110 on the same edge as chg_ack -> chg_rem=14. With W=8, total 250 plus a coin of 10 saturates to 255.
- Mid-operation reset: reset asserted during payout with chg_rem=7 and total=60 -> both 0 next edge, chg_valid=0. sale_count=255 plus one more sale wraps to 0.
